// File: rtl/sdp_ram_pkg.sv
// sdp_ram_pkg: shared types and constants for sdp_ram.
// Holds the clear FSM state enum and the RD_MODE collision-policy codes.
package sdp_ram_pkg;
   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} clr_state_e;
   localparam int RD_FIRST = 0;
   localparam int WR_FIRST = 1;
endpackage

// File: rtl/sdp_ram_clr_ctrl.sv
// sdp_ram_clr_ctrl: memory clear sequencer for sdp_ram.
// Ports: clk_i/rst_i clock and sync reset; clr_i clear request pulse;
// busy_o clear in progress; clr_we_o/clr_addr_o zero-write strobe and address.
module sdp_ram_clr_ctrl
   import sdp_ram_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clr_i,
   output logic                  busy_o,
   output logic                  clr_we_o,
   output logic [ADDR_WIDTH-1:0] clr_addr_o
);
   clr_state_e            r_state;
   clr_state_e            w_next;
   logic [ADDR_WIDTH-1:0] r_cnt;

   // Reset parks the FSM in CLEAR at address 0, so a sweep starts on release.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= CLEAR;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= (r_state == CLEAR) ? r_cnt + 1'b1 : '0;
      end
   end

   // Counter wraps to zero exactly as the last address is written.
   always_comb begin
      w_next = (r_state == IDLE) ? (clr_i ? CLEAR : IDLE) : (&r_cnt ? IDLE : CLEAR);
   end

   assign busy_o     = (r_state == CLEAR);
   assign clr_we_o   = busy_o;
   assign clr_addr_o = r_cnt;
endmodule

// File: rtl/sdp_ram.sv
// sdp_ram: simple dual-port RAM with byte enables, 1/2-cycle read and sweep clear.
// Ports: clk_i/rst_i clock and sync reset; clr_i clear request; busy_o clear active;
// wr_* byte-masked write port; rd_en_i/rd_addr_i read request;
// rd_data_o/rd_valid_o read response after RD_LATENCY cycles.
module sdp_ram
   import sdp_ram_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int BYTE_WIDTH = 8,
   parameter int RD_LATENCY = 1,
   parameter int RD_MODE    = 0
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             clr_i,
   output logic                             busy_o,
   input  logic                             wr_en_i,
   input  logic [ADDR_WIDTH-1:0]            wr_addr_i,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be_i,
   input  logic [DATA_WIDTH-1:0]            wr_data_i,
   input  logic                             rd_en_i,
   input  logic [ADDR_WIDTH-1:0]            rd_addr_i,
   output logic [DATA_WIDTH-1:0]            rd_data_o,
   output logic                             rd_valid_o
);
   localparam int DEPTH  = 2**ADDR_WIDTH;
   localparam int NBYTES = DATA_WIDTH/BYTE_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic                  w_clr_we;
   logic [ADDR_WIDTH-1:0] w_clr_addr;
   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic [DATA_WIDTH-1:0] w_mask;
   logic [DATA_WIDTH-1:0] w_rd_word;
   logic                  r_v1;
   logic [DATA_WIDTH-1:0] r_d1;

   sdp_ram_clr_ctrl #(.ADDR_WIDTH(ADDR_WIDTH)) u_clr (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clr_i      (clr_i),
      .busy_o     (busy_o),
      .clr_we_o   (w_clr_we),
      .clr_addr_o (w_clr_addr)
   );

   assign w_wr_acc = wr_en_i && !busy_o;
   assign w_rd_acc = rd_en_i && !busy_o;

   always_comb begin
      w_mask = '0;
      for (int b = 0; b < NBYTES; b++) w_mask[b*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{wr_be_i[b]}};
   end

   // Write-first forwards the enabled write lanes onto a same-address read.
   always_comb begin
      w_rd_word = r_mem[rd_addr_i];
      if (RD_MODE == WR_FIRST && w_wr_acc && wr_addr_i == rd_addr_i)
         w_rd_word = (w_rd_word & ~w_mask) | (wr_data_i & w_mask);
   end

   // Array has no reset; it is zeroed only by the clear sweep.
   always_ff @(posedge clk_i) begin
      if (w_clr_we) r_mem[w_clr_addr] <= '0;
      else if (w_wr_acc)
         for (int b = 0; b < NBYTES; b++)
            if (wr_be_i[b]) r_mem[wr_addr_i][b*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data_i[b*BYTE_WIDTH +: BYTE_WIDTH];
   end

   // Data registers load only on valid, so the output holds between responses.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_v1 <= 1'b0;
         r_d1 <= '0;
      end else begin
         r_v1 <= w_rd_acc;
         if (w_rd_acc) r_d1 <= w_rd_word;
      end
   end

   generate
      if (RD_LATENCY == 2) begin : g_lat2
         logic                  r_v2;
         logic [DATA_WIDTH-1:0] r_d2;
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               r_v2 <= 1'b0;
               r_d2 <= '0;
            end else begin
               r_v2 <= r_v1;
               if (r_v1) r_d2 <= r_d1;
            end
         end
         assign rd_valid_o = r_v2;
         assign rd_data_o  = r_d2;
      end else begin : g_lat1
         assign rd_valid_o = r_v1;
         assign rd_data_o  = r_d1;
      end
   endgenerate
endmodule

// File: doc/sdp_ram.md
SDP_RAM -- requirements
Module: sdp_ram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word address width; DEPTH = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width, integer multiple of BYTE_WIDTH.
REQ-003 SHALL have parameter BYTE_WIDTH, default 8, write-enable granularity; NBYTES = DATA_WIDTH/BYTE_WIDTH.
REQ-004 SHALL have parameter RD_LATENCY, default 1, read latency in cycles, legal values 1 or 2.
REQ-005 SHALL have parameter RD_MODE, default 0, same-address collision policy: 0 = read-first, 1 = write-first.
REQ-006 SHALL have port clk_i, input, 1 bit, sole clock; all logic on its rising edge.
REQ-007 SHALL have port rst_i, input, 1 bit, synchronous active-high reset.
REQ-008 SHALL have port clr_i, input, 1 bit, pulse requesting a full memory clear.
REQ-009 SHALL have port busy_o, output, 1 bit, clear in progress; accesses ignored.
REQ-010 SHALL have ports wr_en_i (1), wr_addr_i (ADDR_WIDTH), wr_be_i (NBYTES) and wr_data_i (DATA_WIDTH), all inputs, forming the write port.
REQ-011 SHALL have ports rd_en_i (1) and rd_addr_i (ADDR_WIDTH), both inputs, forming the read request.
REQ-012 SHALL have ports rd_data_o (DATA_WIDTH) and rd_valid_o (1), both outputs, forming the read response.

Function
REQ-013 Write SHALL occur when wr_en_i=1 and busy_o=0: byte lane b is updated from wr_data_i only if wr_be_i[b]=1; other lanes SHALL keep their value.
REQ-014 Read SHALL be accepted when rd_en_i=1 and busy_o=0; rd_data_o and rd_valid_o=1 SHALL appear exactly RD_LATENCY cycles later, for one cycle per accepted read.
REQ-015 Back-to-back reads SHALL give one response per cycle, in order, with no bubbles.
REQ-016 rd_data_o SHALL hold its last value when rd_valid_o=0.
REQ-017 Collision (read and write to the same address in the same cycle): with RD_MODE=0 the read SHALL return pre-write data; with RD_MODE=1 it SHALL return pre-write data with the enabled lanes replaced by wr_data_i.
REQ-018 Clear FSM SHALL have states IDLE and CLEAR; busy_o=1 exactly when the state is CLEAR.
REQ-019 In CLEAR, each cycle SHALL write zero to address clr_cnt and increment clr_cnt; after writing DEPTH-1 the FSM SHALL go to IDLE on the next edge.
REQ-020 clr_i=1 in IDLE SHALL cause CLEAR with clr_cnt=0 on the next edge; clr_i in CLEAR SHALL be ignored (no restart).
REQ-021 busy_o SHALL be high for exactly DEPTH cycles per clear, whether started by clr_i or by reset release.
REQ-022 wr_en_i and rd_en_i SHALL be ignored while busy_o=1; a write and clr_i in the same IDLE cycle SHALL perform the write, which the clear then overwrites.
REQ-023 Reads accepted before clear entry SHALL complete normally, with data read at acceptance time.
REQ-024 clr_cnt SHALL be ADDR_WIDTH bits and SHALL wrap only at the CLEAR to IDLE exit.

Reset
REQ-025 While rst_i=1: state=CLEAR, clr_cnt=0, busy_o=1, rd_valid_o=0, rd_data_o=0, read pipeline flushed.
REQ-026 Clearing SHALL begin on the first cycle after rst_i falls; reset mid-clear SHALL restart from address 0.
REQ-027 Memory contents SHALL NOT be reset directly; zeroing is done only by the CLEAR sweep.

Structure
REQ-028 A shared package sdp_ram_pkg SHALL hold the FSM state enum (IDLE, CLEAR) and the RD_MODE constants RD_FIRST=0 and WR_FIRST=1.
REQ-029 The FSM and counter SHALL live in sub-module sdp_ram_clr_ctrl, which outputs busy, clear write-enable and clear address; the array, byte merge and read pipeline stay in sdp_ram.

Verification (ADDR_WIDTH=4, DATA_WIDTH=32, BYTE_WIDTH=8)
REQ-030 Reset for 3 cycles then release -> busy_o high for exactly 16 cycles; afterwards reads of addresses 0..15 return 0x00000000.
REQ-031 Write 0xAABBCCDD to addr 3 with be=1111, then write 0x11223344 to addr 3 with be=0101, read addr 3 -> 0xAA22CC44 after RD_LATENCY cycles, rd_valid_o high for 1 cycle.
REQ-032 Addr 5 holds 0x0; same-cycle write of 0xFFFFFFFF (be=0011) and read of addr 5 -> RD_MODE=0 returns 0x00000000, RD_MODE=1 returns 0x0000FFFF.
REQ-033 Reads of addrs 0..7 on consecutive cycles, RD_LATENCY=2 -> 8 consecutive valid responses, in order, first one 2 cycles after the first request.
REQ-034 clr_i pulse, then wr_en_i and rd_en_i at clear cycle 4, and clr_i again at cycle 6 -> no write or read response, busy_o still exactly 16 cycles, all words read back 0.
REQ-035 rst_i asserted at clear cycle 8 for 1 cycle -> rd_valid_o=0, and after release busy_o high for 16 fresh cycles.
